// File: rtl/clint_timer.sv
// Core-local interruptor: msip / mtimecmp / mtime registers behind a one-outstanding bus.
// Define CLINT_MTIME_WRITE_EN to make mtime writable; otherwise a write to mtime faults.
module clint_timer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int PRESCALE   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic [DATA_WIDTH-1:0]   mtime_o,
  output logic                    timer_interrupt,
  output logic                    software_interrupt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [PW-1:0]           presc_reg, presc_next;
  logic [DATA_WIDTH-1:0]   mtime_reg, mtime_next;
  logic [DATA_WIDTH-1:0]   mtimecmp_reg, mtimecmp_next;
  logic                    msip_reg, msip_next;
  logic                    timer_irq_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_error_reg, rsp_error_next;
  logic [DATA_WIDTH-1:0]   wmask;
  logic                    tick;
  logic                    aligned;
  logic                    sel_msip, sel_cmp, sel_mtime;
  logic                    mtime_writable;
  logic                    hit;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
    end
  endgenerate

`ifdef CLINT_MTIME_WRITE_EN
  assign mtime_writable = 1'b1;
`else
  assign mtime_writable = 1'b0;
`endif

  assign tick       = (presc_reg == PW'(PRESCALE - 1));
  assign presc_next = tick ? '0 : presc_reg + 1'b1;

  assign aligned   = (req_addr[2:0] == 3'b000);
  assign sel_msip  = aligned && (req_addr == ADDR_WIDTH'(16'h0000));
  assign sel_cmp   = aligned && (req_addr == ADDR_WIDTH'(16'h4000));
  assign sel_mtime = aligned && (req_addr == ADDR_WIDTH'(16'hBFF8));
  assign hit       = sel_msip || sel_cmp || (sel_mtime && (!req_write || mtime_writable));

  always_comb begin
    state_next     = state_reg;
    mtime_next     = tick ? mtime_reg + 1'b1 : mtime_reg;
    mtimecmp_next  = mtimecmp_reg;
    msip_next      = msip_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_error_next = rsp_error_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next     = RESP;
          rsp_error_next = !hit;
          rsp_rdata_next = '0;
          if (hit) begin
            if (req_write) begin
              if (sel_msip && req_wstrb[0]) msip_next = req_wdata[0];
              if (sel_cmp) mtimecmp_next = (mtimecmp_reg & ~wmask) | (req_wdata & wmask);
              // A bus write to mtime overrides the tick in the same cycle.
              if (sel_mtime) mtime_next = (mtime_reg & ~wmask) | (req_wdata & wmask);
            end else begin
              if (sel_msip)  rsp_rdata_next = {{(DATA_WIDTH-1){1'b0}}, msip_reg};
              if (sel_cmp)   rsp_rdata_next = mtimecmp_reg;
              if (sel_mtime) rsp_rdata_next = mtime_reg;
            end
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      mtime_reg     <= '0;
      mtimecmp_reg  <= '1;
      msip_reg      <= 1'b0;
      timer_irq_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      mtime_reg     <= mtime_next;
      mtimecmp_reg  <= mtimecmp_next;
      msip_reg      <= msip_next;
      // Compares the registered values, so the flag trails any change by one cycle.
      timer_irq_reg <= (mtime_reg >= mtimecmp_reg);
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  assign req_ready          = (state_reg == IDLE);
  assign rsp_valid          = (state_reg == RESP);
  assign rsp_rdata          = rsp_rdata_reg;
  assign rsp_error          = rsp_error_reg;
  assign mtime_o            = mtime_reg;
  assign timer_interrupt    = timer_irq_reg;
  assign software_interrupt = msip_reg;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (default build, PRESCALE=4); mtime-write checks follow CLINT_MTIME_WRITE_EN.
module tb_clint_timer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic [63:0] mtime_o;
  logic        timer_interrupt;
  logic        software_interrupt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clint_timer #(.DATA_WIDTH(64), .ADDR_WIDTH(16), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mtime_o(mtime_o), .timer_interrupt(timer_interrupt),
    .software_interrupt(software_interrupt)
  );

  // Issues one access, returns #1 after the accept edge with the response sampled.
  task automatic bus_access(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wstrb, output logic [63:0] rdata,
                            output logic err, output logic [63:0] mtime_seen);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    mtime_seen = mtime_o;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_latency addr=%h got rsp_valid=%b want 1", addr, rsp_valid);
    end
    rdata = rsp_rdata;
    err = rsp_error;
    $display("access wr=%0b addr=%h wdata=%h strb=%h -> rdata=%h err=%0b", wr, addr, wdata, wstrb, rdata, err);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_error, mtime_o, timer_interrupt, software_interrupt}
        !== {1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b mtime=%h ti=%b si=%b",
               req_ready, rsp_valid, rsp_rdata, rsp_error, mtime_o, timer_interrupt, software_interrupt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (mtime_o !== 64'd10) begin
      bad++;
      $display("FAIL idle40_mtime got %0d want 10", mtime_o);
    end
    total++;
    if (timer_interrupt !== 1'b0) begin
      bad++;
      $display("FAIL idle40_irq got %b want 0", timer_interrupt);
    end
    $display("reset: mtime after 40 idle cycles = %0d", mtime_o);
  endtask

  task automatic test_timer();
    logic [63:0] rd, ms;
    logic er;
    bit found;
    found = 1'b0;
    bus_access(1'b1, 16'h4000, 64'd20, 8'hFF, rd, er, ms);
    total++;
    if ({er, rd} !== {1'b0, 64'd0}) begin
      bad++;
      $display("FAIL cmp_write_rsp got err=%b rdata=%h want err=0 rdata=0", er, rd);
    end
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mtime_o == 64'd20) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mtime_reach20 timed out, mtime=%0d", mtime_o);
    end else begin
      if (timer_interrupt !== 1'b0) begin
        bad++;
        $display("FAIL irq_at_match got %b want 0", timer_interrupt);
      end
      @(posedge clk);
      #1;
      total++;
      if (timer_interrupt !== 1'b1) begin
        bad++;
        $display("FAIL irq_rise got %b want 1", timer_interrupt);
      end
      $display("timer: irq rose one cycle after mtime=20");
    end
    bus_access(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, ms);
    total++;
    if (timer_interrupt !== 1'b1) begin
      bad++;
      $display("FAIL irq_hold_on_write got %b want 1", timer_interrupt);
    end
    @(posedge clk);
    #1;
    total++;
    if (timer_interrupt !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall got %b want 0", timer_interrupt);
    end
  endtask

  task automatic test_msip();
    logic [63:0] rd, ms;
    logic er;
    bus_access(1'b1, 16'h0000, 64'hFFFF, 8'h01, rd, er, ms);
    @(posedge clk);
    #1;
    total++;
    if (software_interrupt !== 1'b1) begin
      bad++;
      $display("FAIL msip_set got si=%b want 1", software_interrupt);
    end
    bus_access(1'b0, 16'h0000, 64'd0, 8'h00, rd, er, ms);
    total++;
    if ({er, rd} !== {1'b0, 64'd1}) begin
      bad++;
      $display("FAIL msip_read got err=%b rdata=%h want err=0 rdata=1", er, rd);
    end
    bus_access(1'b1, 16'h0000, 64'd0, 8'hFF, rd, er, ms);
    @(posedge clk);
    #1;
    total++;
    if (software_interrupt !== 1'b0) begin
      bad++;
      $display("FAIL msip_clear got si=%b want 0", software_interrupt);
    end
    bus_access(1'b1, 16'h0000, 64'd1, 8'h00, rd, er, ms);
    @(posedge clk);
    #1;
    total++;
    if ({er, software_interrupt} !== 2'b00) begin
      bad++;
      $display("FAIL strb0_noop got err=%b si=%b want err=0 si=0", er, software_interrupt);
    end
  endtask

  task automatic test_mtime();
    logic [63:0] rd, ms;
    logic er;
    bus_access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er, ms);
    total++;
    if ({er, rd} !== {1'b0, ms}) begin
      bad++;
      $display("FAIL mtime_read got err=%b rdata=%h want err=0 rdata=%h", er, rd, ms);
    end
    bus_access(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, ms);
`ifdef CLINT_MTIME_WRITE_EN
    total++;
    if ({er, mtime_o} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      bad++;
      $display("FAIL mtime_write got err=%b mtime=%h want err=0 mtime=fffffffffffffffe", er, mtime_o);
    end
    for (int i = 0; i < 8 && mtime_o == 64'hFFFF_FFFF_FFFF_FFFE; i++) begin @(posedge clk); #1; end
    total++;
    if (mtime_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL mtime_step1 got %h want ffffffffffffffff", mtime_o);
    end
    for (int i = 0; i < 8 && mtime_o == 64'hFFFF_FFFF_FFFF_FFFF; i++) begin @(posedge clk); #1; end
    total++;
    if (mtime_o !== 64'd0) begin
      bad++;
      $display("FAIL mtime_wrap got %h want 0", mtime_o);
    end
`else
    total++;
    if ({er, rd} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL mtime_write_ro got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    total++;
    if (mtime_o > 64'd1000) begin
      bad++;
      $display("FAIL mtime_unchanged got %h want small running value", mtime_o);
    end
`endif
  endtask

  task automatic test_errors();
    logic [63:0] rd, ms;
    logic er;
    bus_access(1'b0, 16'h4004, 64'd0, 8'h00, rd, er, ms);
    total++;
    if ({er, rd} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL err_unaligned got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    bus_access(1'b0, 16'h1000, 64'd0, 8'h00, rd, er, ms);
    total++;
    if ({er, rd} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL err_unmapped got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    bus_access(1'b1, 16'h0004, 64'd1, 8'hFF, rd, er, ms);
    @(posedge clk);
    #1;
    total++;
    if ({er, software_interrupt} !== 2'b10) begin
      bad++;
      $display("FAIL err_write_nochange got err=%b si=%b want err=1 si=0", er, software_interrupt);
    end
    bus_access(1'b0, 16'h4000, 64'd0, 8'h00, rd, er, ms);
    total++;
    if ({er, rd} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      bad++;
      $display("FAIL cmp_readback got err=%b rdata=%h want err=0 rdata=ffffffffffffffff", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int n, cnt;
    n = 0;
    cnt = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000; req_wstrb = 8'h00;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) cnt++;
    end
    req_valid = 1'b0;
    total++;
    if (cnt !== 5) begin
      bad++;
      $display("FAIL back_to_back got %0d responses want 5", cnt);
    end
    $display("back_to_back: %0d responses in 10 cycles", cnt);
  endtask

  task automatic test_hold_reset();
    logic [63:0] rd, ms;
    logic er;
    rsp_ready = 1'b0;
    bus_access(1'b0, 16'h4000, 64'd0, 8'h00, rd, er, ms);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({rsp_valid, req_ready, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
        bad++;
        $display("FAIL hold_cycle%0d got valid=%b ready=%b err=%b rdata=%h", i, rsp_valid, req_ready, rsp_error, rsp_rdata);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_error, mtime_o, timer_interrupt, software_interrupt}
        !== {1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_hold got ready=%b valid=%b rdata=%h err=%b mtime=%h ti=%b si=%b",
               req_ready, rsp_valid, rsp_rdata, rsp_error, mtime_o, timer_interrupt, software_interrupt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    $display("hold_reset: async reset dropped pending response");
  endtask

  initial begin
    test_reset();
    test_timer();
    test_msip();
    test_mtime();
    test_errors();
    test_back_to_back();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
